stream_demux_1xn: RTL

//  Registered 1-to-N packet demultiplexer with valid/ready handshake on every port.

---
 rtl/stream_demux_1xn_if.sv | 38 +++
 rtl/stream_demux_1xn.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/stream_demux_1xn_if.sv
// ---------------------------------------------------------------------------
// stream_demux_1xn_if
// Groups the upstream and per-channel downstream valid/ready stream signals of
// the 1-to-N packet demultiplexer.
//   in_valid / in_ready / in_data / in_sel / in_last : single upstream stream
//   out_valid / out_ready / out_data / out_last       : N downstream streams,
//                                                       channel k payload at
//                                                       out_data[k*DW +: DW]
// Modports:
//   master : the side that feeds the demux and consumes its outputs
//   slave  : the demux itself
// ---------------------------------------------------------------------------
interface stream_demux_1xn_if #(
    parameter int DW = 8,
    parameter int N  = 4
);
    localparam int SW = (N > 2) ? $clog2(N) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic          in_last;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_last;

    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// stream_demux_1xn
// Registered 1-to-N packet demultiplexer. The destination channel is taken
// from in_sel on the first beat of a packet and held until its last beat.
// Each channel has a one-entry output register with valid/ready backpressure;
// packets addressed to a non-existent channel are swallowed and counted.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : stream interface (slave modport), see stream_demux_1xn_if
//   busy     : high while inside a forwarded or dropped multi-beat packet
//   drop_cnt : saturating count of dropped packets
// ---------------------------------------------------------------------------
module stream_demux_1xn #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_demux_1xn_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int SW = (N > 2) ? $clog2(N) : 1;
    // Padded to a power of two so indexing by an out-of-range select is safe.
    localparam int NP = 1 << SW;

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] cur_ch;
    logic [SW-1:0] route_ch;
    logic [N-1:0]  slot_valid;
    logic [N-1:0]  slot_last;
    logic [DW-1:0] slot_data [N];
    logic [NP-1:0] free_pad;
    logic          sel_ok;
    logic          rdy;
    logic          accept;
    logic          fwd;
    logic          drop_hit;
    logic          latch_ch;

    // A slot can take a new beat when empty or when it is being drained this
    // cycle, which gives one beat per cycle per channel.
    always_comb begin
        free_pad         = '0;
        free_pad[N-1:0]  = ~slot_valid | bus.out_ready;
    end

    assign sel_ok = ({1'b0, bus.in_sel} < (SW + 1)'(N));

    // Ready, routing and next-state decode. Ready never depends on in_valid,
    // and is forced low while reset is asserted.
    always_comb begin
        rdy       = 1'b0;
        fwd       = 1'b0;
        route_ch  = cur_ch;
        state_nxt = state;
        drop_hit  = 1'b0;
        latch_ch  = 1'b0;
        case (state)
            IDLE: begin
                route_ch = bus.in_sel;
                if (sel_ok) begin
                    rdy = free_pad[bus.in_sel];
                    fwd = 1'b1;
                end else begin
                    rdy = 1'b1;
                end
            end
            BUSY: begin
                rdy = free_pad[cur_ch];
                fwd = 1'b1;
            end
            DROP: rdy = 1'b1;
            default: rdy = 1'b0;
        endcase

        accept = bus.in_valid & rdy & rst_n;

        if (accept) begin
            case (state)
                IDLE: begin
                    if (!sel_ok) begin
                        drop_hit = 1'b1;
                        if (!bus.in_last) state_nxt = DROP;
                    end else if (!bus.in_last) begin
                        latch_ch  = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY:    if (bus.in_last) state_nxt = IDLE;
                DROP:    if (bus.in_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.in_ready = rdy & rst_n;
    assign busy         = (state != IDLE);

    // Packet state, latched destination and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_ch   <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (latch_ch) cur_ch <= bus.in_sel;
            if (drop_hit && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Per-channel output registers: load on a forwarded beat, otherwise clear
    // valid once the consumer takes the beat; data/last hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            slot_last  <= '0;
            for (int k = 0; k < N; k++) slot_data[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (accept && fwd && (route_ch == SW'(k))) begin
                    slot_valid[k] <= 1'b1;
                    slot_last[k]  <= bus.in_last;
                    slot_data[k]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < N; k++) bus.out_data[k*DW +: DW] = slot_data[k];
    end

    assign bus.out_valid = slot_valid;
    assign bus.out_last  = slot_last;
endmodule
